// File: rtl/matrix_read_sequencer.sv
// Streams a contiguous range of matrix layers out of row-addressed storage,
// one row per cycle, through a single registered valid/ready output stage.
module matrix_read_sequencer #(
  parameter int size      = 3,
  parameter int data_size = 16,
  parameter int max_layer = 36
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               start_layer,
  input  logic [31:0]               layer_count,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [31:0]               mem_read_layer_index,
  output logic [31:0]               mem_read_row_index,
  output logic                      mem_is_read,
  input  logic [data_size*size-1:0] mem_read_data,
  output logic [data_size*size-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_layer_index,
  output logic [31:0]               out_row_index,
  output logic                      out_last
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]               layer_q, layer_d;
  logic [31:0]               row_q, row_d;
  logic [31:0]               last_layer_q, last_layer_d;
  logic [data_size*size-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic [31:0]               out_layer_q, out_layer_d;
  logic [31:0]               out_row_q, out_row_d;
  logic                      out_last_q, out_last_d;
  logic                      error_q, error_d;

  logic [32:0] req_end;
  logic        req_ok;
  logic        start_accept;
  logic        row_wrap;
  logic        final_row;

  // The 33-bit sum keeps a huge start_layer from wrapping into a "valid" range.
  assign req_end      = {1'b0, start_layer} + {1'b0, layer_count};
  assign req_ok       = (layer_count != 32'd0) && (req_end <= 33'(max_layer));
  assign start_accept = (state_q == IDLE) && start && req_ok;
  assign row_wrap     = (row_q == 32'(size - 1));
  assign final_row    = row_wrap && (layer_q == last_layer_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_accept) state_d = STREAM;
      STREAM:  if (mem_is_read && final_row) state_d = DRAIN;
      DRAIN:   if (out_valid_q && out_ready && out_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy                 = (state_q != IDLE);
    done                 = (state_q == DONE);
    mem_is_read          = (state_q == STREAM) && (!out_valid_q || out_ready);
    mem_read_layer_index = '0;
    mem_read_row_index   = '0;
    if (state_q == STREAM) begin
      mem_read_layer_index = layer_q;
      mem_read_row_index   = row_q;
    end
  end

  // NOTE: every variable starts from a hold/default value so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    layer_d      = layer_q;
    row_d        = row_q;
    last_layer_d = last_layer_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_layer_d  = out_layer_q;
    out_row_d    = out_row_q;
    out_last_d   = out_last_q;
    error_d      = (state_q == IDLE) && start && !req_ok;

    if (start_accept) begin
      layer_d      = start_layer;
      row_d        = '0;
      last_layer_d = start_layer + layer_count - 32'd1;
    end

    if (mem_is_read) begin
      out_data_d  = mem_read_data;
      out_layer_d = layer_q;
      out_row_d   = row_q;
      out_last_d  = final_row;
      out_valid_d = 1'b1;
      // Counters park on the final row so they never point past the range.
      if (!final_row) begin
        if (row_wrap) begin
          row_d   = '0;
          layer_d = layer_q + 32'd1;
        end else begin
          row_d = row_q + 32'd1;
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layer_q      <= '0;
      row_q        <= '0;
      last_layer_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_layer_q  <= '0;
      out_row_q    <= '0;
      out_last_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      layer_q      <= layer_d;
      row_q        <= row_d;
      last_layer_q <= last_layer_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_layer_q  <= out_layer_d;
      out_row_q    <= out_row_d;
      out_last_q   <= out_last_d;
      error_q      <= error_d;
    end
  end

  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign out_layer_index = out_layer_q;
  assign out_row_index   = out_row_q;
  assign out_last        = out_last_q;
  assign error           = error_q;

endmodule

// File: tb/tb_matrix_read_sequencer.sv
// Scoreboard bench for matrix_read_sequencer: stimulus pushes expected rows,
// a negedge monitor pops and compares every accepted row.
module tb_matrix_read_sequencer;

  localparam int SIZE = 3;
  localparam int DW   = 16;
  localparam int ML   = 36;
  localparam int RW   = DW * SIZE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   start_layer = '0;
  logic [31:0]   layer_count = '0;
  logic          busy, done, error;
  logic [31:0]   mem_read_layer_index, mem_read_row_index;
  logic          mem_is_read;
  logic [RW-1:0] mem_read_data, out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_layer_index, out_row_index;
  logic          out_last;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int ready_mode = 0;
  int err_cnt = 0, rd_cnt = 0, done_cnt = 0, busy_cnt = 0, acc_cnt = 0;
  int acc_cyc[$];

  typedef struct {
    logic [31:0]   layer;
    logic [31:0]   row;
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  matrix_read_sequencer #(.size(SIZE), .data_size(DW), .max_layer(ML)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .start_layer          (start_layer),
    .layer_count          (layer_count),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .mem_read_layer_index (mem_read_layer_index),
    .mem_read_row_index   (mem_read_row_index),
    .mem_is_read          (mem_is_read),
    .mem_read_data        (mem_read_data),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_layer_index      (out_layer_index),
    .out_row_index        (out_row_index),
    .out_last             (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Distinct contents per (layer, row, element).
  function automatic logic [RW-1:0] model_row(input logic [31:0] l, input logic [31:0] r);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < SIZE; k++) v[k*DW +: DW] = DW'(l * 256 + r * 16 + 32'(k) + 1);
    return v;
  endfunction

  // Storage model: returns all-ones when not strobed so stray captures show.
  always_comb mem_read_data = mem_is_read ? model_row(mem_read_layer_index, mem_read_row_index) : '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data;
  logic [31:0]   prev_l, prev_r;

  always @(negedge clk) begin
    if (rst_n) begin
      if (error)       err_cnt++;
      if (mem_is_read) rd_cnt++;
      if (done)        done_cnt++;
      if (busy)        busy_cnt++;
      if (prev_stall) begin
        check("stall_valid_held", 64'(out_valid), 64'(1));
        check("stall_data_held", 64'(out_data), 64'(prev_data));
        check("stall_layer_held", 64'(out_layer_index), 64'(prev_l));
        check("stall_row_held", 64'(out_row_index), 64'(prev_r));
      end
      if (out_valid && !out_ready) check("stall_no_read", 64'(mem_is_read), 64'(0));
      if (out_valid && out_ready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        check("row_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("out_layer", 64'(out_layer_index), 64'(mon_e.layer));
          check("out_row", 64'(out_row_index), 64'(mon_e.row));
          check("out_data", 64'(out_data), 64'(mon_e.data));
          check("out_last", 64'(out_last), 64'(mon_e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_l     = out_layer_index;
      prev_r     = out_row_index;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_mem_is_read"}, 64'(mem_is_read), 64'(0));
    check({tag, "_rd_layer"}, 64'(mem_read_layer_index), 64'(0));
    check({tag, "_rd_row"}, 64'(mem_read_row_index), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_layer"}, 64'(out_layer_index), 64'(0));
    check({tag, "_out_row"}, 64'(out_row_index), 64'(0));
    check({tag, "_out_last"}, 64'(out_last), 64'(0));
  endtask

  task automatic push_expected(input logic [31:0] sl, input logic [31:0] lc);
    for (int l = 0; l < int'(lc); l++)
      for (int r = 0; r < SIZE; r++)
        sb.push_back('{layer: sl + 32'(l), row: 32'(r),
                       data: model_row(sl + 32'(l), 32'(r)),
                       last: (l == int'(lc) - 1) && (r == SIZE - 1)});
  endtask

  task automatic pulse_start(input logic [31:0] sl, input logic [31:0] lc);
    @(posedge clk);
    #1;
    start = 1'b1; start_layer = sl; layer_count = lc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_transfer(input logic [31:0] sl, input logic [31:0] lc, input int mode,
                              input bit timing, input bit inject);
    int c0, n, e0, d0;
    ready_mode = mode;
    push_expected(sl, lc);
    e0 = err_cnt;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1; start_layer = sl; layer_count = lc;
    c0 = cyc;
    acc_cyc.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("first_read_strobe", 64'(mem_is_read), 64'(1));
    check("first_read_busy", 64'(busy), 64'(1));
    check("first_read_layer", 64'(mem_read_layer_index), 64'(sl));
    check("first_read_row", 64'(mem_read_row_index), 64'(0));
    if (inject) pulse_start(32'd10, 32'd1);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("rows_delivered", 64'(acc_cyc.size()), 64'(lc * SIZE));
    if (timing && acc_cyc.size() == int'(lc) * SIZE) begin
      check("first_accept_cyc", 64'(acc_cyc[0]), 64'(c0 + 2));
      for (int i = 1; i < acc_cyc.size(); i++)
        check("accept_back_to_back", 64'(acc_cyc[i]), 64'(acc_cyc[0] + i));
      check("done_after_last", 64'(cyc), 64'(acc_cyc[acc_cyc.size()-1] + 1));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    check("no_error_pulse", 64'(err_cnt - e0), 64'(0));
    check("single_done", 64'(done_cnt - d0), 64'(1));
    sb.delete();
  endtask

  task automatic bad_start(input logic [31:0] sl, input logic [31:0] lc);
    int e0, r0, b0;
    e0 = err_cnt; r0 = rd_cnt; b0 = busy_cnt;
    pulse_start(sl, lc);
    repeat (3) @(negedge clk);
    check("reject_error_once", 64'(err_cnt - e0), 64'(1));
    check("reject_no_read", 64'(rd_cnt - r0), 64'(0));
    check("reject_not_busy", 64'(busy_cnt - b0), 64'(0));
  endtask

  initial begin
    int a0, n, d0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_transfer(32'd2, 32'd1, 0, 1'b1, 1'b0);
    run_transfer(32'd0, 32'd2, 1, 1'b0, 1'b0);
    run_transfer(32'd35, 32'd1, 0, 1'b1, 1'b0);
    bad_start(32'd35, 32'd2);
    bad_start(32'd0, 32'd0);
    bad_start(32'hFFFF_FFFF, 32'd2);
    run_transfer(32'd4, 32'd2, 0, 1'b1, 1'b1);

    // Reset in the middle of a two-layer transfer.
    ready_mode = 0;
    push_expected(32'd1, 32'd2);
    a0 = acc_cnt;
    pulse_start(32'd1, 32'd2);
    n = 0;
    while (acc_cnt < a0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("two_rows_before_reset", 64'(acc_cnt - a0), 64'(2));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    check_all_zero("mid_reset");
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt - d0), 64'(0));
    run_transfer(32'd5, 32'd1, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/matrix_read_sequencer.md
MATRIX_READ_SEQUENCER -- requirements
Module: matrix_read_sequencer

Interface
REQ-001 Parameters SHALL be: size, default 3, matrix dimension (rows per layer and elements per row); data_size, default 16, bits per element; max_layer, default 36, number of layers held in the matrix storage.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state changes on the rising edge
  rst_n  in  1  reset, synchronous, active-low
  start  in  1  request to stream layers; sampled only in IDLE
  start_layer  in  32  first layer index to stream
  layer_count  in  32  number of consecutive layers to stream
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle pulse after the final row is accepted
  error  out  1  one-cycle pulse when start is rejected
  mem_read_layer_index  out  32  layer index driven to the storage read port
  mem_read_row_index  out  32  row index driven to the storage read port
  mem_is_read  out  1  storage read strobe
  mem_read_data  in  data_size*size  storage row data, combinational from the index and strobe
  out_data  out  data_size*size  registered row presented to the consumer
  out_valid  out  1  out_data is valid
  out_ready  in  1  consumer accepts out_data
  out_layer_index  out  32  layer of the row in out_data
  out_row_index  out  32  row of the row in out_data
  out_last  out  1  out_data is the last row of the last layer

Function
REQ-003 The FSM SHALL have states IDLE, STREAM, DRAIN and DONE.
REQ-004 In IDLE with start=1 and a valid request, the block SHALL capture start_layer and layer_count, clear the row counter, and enter STREAM on the next edge.
REQ-005 A request is valid iff layer_count != 0 and start_layer + layer_count <= max_layer, computed without overflow (33-bit sum).
REQ-006 An invalid start SHALL pulse error for one cycle and leave the block in IDLE; no memory read is issued.
REQ-007 Start while busy=1 SHALL be ignored.
REQ-008 mem_is_read SHALL equal (state==STREAM) && (!out_valid || out_ready); the index outputs SHALL carry the current layer and row counters whenever in STREAM, and 0 otherwise.
REQ-009 On each edge where mem_is_read=1, the block SHALL:
  - load out_data from mem_read_data and load out_layer_index/out_row_index from the counters;
  - set out_valid=1;
  - advance the row counter, wrapping from size-1 to 0 and incrementing the layer counter on wrap.
REQ-010 Throughput SHALL be one row per cycle while out_ready=1. The first mem_is_read SHALL occur in the first STREAM cycle; out_valid SHALL rise one cycle later.
REQ-011 When out_valid=1 and out_ready=0, out_data and its tags SHALL hold stable and mem_is_read SHALL be 0 (no row is skipped or duplicated).
REQ-012 out_valid SHALL clear on an edge where out_valid && out_ready and no new read occurs.
REQ-013 out_last SHALL be 1 exactly when the row in out_data is row size-1 of layer start_layer+layer_count-1.
REQ-014 The issue of that final row SHALL move the FSM STREAM->DRAIN.
REQ-015 In DRAIN, acceptance of the last row (out_valid && out_ready && out_last) SHALL move the FSM to DONE. DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-016 Total rows delivered per request SHALL be layer_count*size, in ascending (layer, row) order.
REQ-017 Counters SHALL never index beyond max_layer-1 or size-1.

Reset
REQ-018 With rst_n=0 at a rising edge, the FSM SHALL enter IDLE and every output SHALL be 0: busy, done, error, mem_is_read, both index outputs, out_data, out_valid, the out tags and out_last.
REQ-019 Reset mid-operation SHALL abandon the transfer with no done pulse; the first start after reset SHALL behave as from power-up.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - Single layer: start_layer=2, layer_count=1, out_ready=1 -> rows (2,0),(2,1),(2,2) on 3 consecutive cycles; out_last on (2,2); done 1 cycle after the last acceptance.
  - Backpressure: start_layer=0, layer_count=2, out_ready toggling 1,0,0,1... -> all 6 rows delivered in order; out_data stable while stalled; mem_is_read=0 while stalled.
  - Boundary: start_layer=35, layer_count=1 -> 3 rows, no error. start_layer=35, layer_count=2 -> error pulse, no mem_is_read, busy stays 0. layer_count=0 -> error.
  - Start while busy: second start mid-stream with different values -> ignored; the first transfer completes unchanged.
  - Reset mid-stream: rst_n=0 after 2 rows -> all outputs 0 next cycle, no done; a new start then streams from row 0.
  - Data check: preload distinct values in the storage model -> out_data matches the model per (layer, row) tag.
